// File: rtl/fod_spi_regfile.sv
// SPI mode-0 slave register file driving the FOD controller control bus.
// SPI pins are synchronized into CLK; writes commit on CSN rise.
module fod_spi_regfile #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] CHIP_ID     = 16'hF0D1
) (
  input  logic        CLK,
  input  logic        NARST,
  input  logic        SCK,
  input  logic        CSN,
  input  logic        MOSI,
  output logic        MISO,
  output logic        WR_STB,
  output logic [22:0] FCW_FOD,
  output logic        SYS_EN,
  output logic        DSM_SYNC_NRST_EN,
  output logic        NCO_SYNC_NRST_EN,
  output logic        FREQ_HOP,
  output logic        RT_EN,
  output logic        PCALI_EN,
  output logic        FREQ_C_EN,
  output logic        FREQ_C_MODE,
  output logic        DTCCALI_EN,
  output logic        OFSTCALI_EN,
  output logic        FCW_DN_EN,
  output logic [1:0]  FCW_DN_WEIGHT,
  output logic [1:0]  PSEG,
  output logic [4:0]  FREQ_C_KS,
  output logic [4:0]  PCALI_KS,
  output logic [2:0]  PCALI_FREQDOWN,
  output logic [1:0]  CALIORDER,
  output logic [9:0]  PHASE_CTRL,
  output logic [4:0]  KB,
  output logic [4:0]  KC,
  output logic [4:0]  KD,
  output logic [9:0]  KDTCB_INIT,
  output logic [9:0]  KDTCC_INIT,
  output logic [9:0]  KDTCD_INIT0,
  output logic [9:0]  KDTCD_INIT1
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sck_s, csn_s, mosi_s;
  logic sck_d, csn_d;
  logic sck_rise_q, csn_rise_q, csn_fall_q, mosi_q;
  logic sck_fall_c;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // CSN synchronizer idles high so reset never fakes a frame start
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], CSN};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign sck_fall_c = ~sck_s & sck_d;

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      sck_d      <= 1'b0;
      csn_d      <= 1'b1;
      sck_rise_q <= 1'b0;
      csn_rise_q <= 1'b0;
      csn_fall_q <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      sck_d      <= sck_s;
      csn_d      <= csn_s;
      sck_rise_q <= sck_s & ~sck_d & ~csn_s;
      csn_rise_q <= csn_s & ~csn_d;
      csn_fall_q <= ~csn_s & csn_d;
      mosi_q     <= mosi_s;
    end
  end

  logic [4:0]  cnt;
  logic [23:0] shreg;
  logic [15:0] shout;
  logic        rd_act;
  logic [6:0]  hdr_addr;
  logic [15:0] rd_word;

  logic [14:0] r0;
  logic [15:0] r1;
  logic [22:0] fcw;
  logic [14:0] r3;
  logic [9:0]  r4;
  logic [14:0] r5;
  logic [9:0]  r6, r7, r8, r9;

  assign hdr_addr = {shreg[5:0], mosi_q};

  always_comb begin
    rd_word = 16'h0000;
    case (hdr_addr)
      7'h00:   rd_word = {1'b0, r0};
      7'h01:   rd_word = r1;
      7'h02:   rd_word = {9'd0, fcw[22:16]};
      7'h03:   rd_word = {1'b0, r3};
      7'h04:   rd_word = {6'd0, r4};
      7'h05:   rd_word = {1'b0, r5};
      7'h06:   rd_word = {6'd0, r6};
      7'h07:   rd_word = {6'd0, r7};
      7'h08:   rd_word = {6'd0, r8};
      7'h09:   rd_word = {6'd0, r9};
      7'h7F:   rd_word = CHIP_ID;
      default: rd_word = 16'h0000;
    endcase
  end

  // Read data is captured once the 8th header bit arrives with RW = 0
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      cnt    <= '0;
      shreg  <= '0;
      shout  <= '0;
      rd_act <= 1'b0;
    end else begin
      if (csn_fall_q) begin
        cnt    <= '0;
        rd_act <= 1'b0;
      end else if (sck_rise_q) begin
        if (cnt != 5'd25) cnt <= cnt + 5'd1;
        shreg <= {shreg[22:0], mosi_q};
        if (cnt == 5'd7 && !shreg[6]) begin
          shout  <= rd_word;
          rd_act <= 1'b1;
        end
      end else if (sck_fall_c && rd_act && cnt >= 5'd9) begin
        shout <= {shout[14:0], 1'b0};
      end
      if (csn_rise_q) rd_act <= 1'b0;
    end
  end

  assign MISO = ~CSN & rd_act & shout[15];

  logic        commit;
  logic [6:0]  wa;
  logic [15:0] wd;

  assign commit = csn_rise_q && cnt == 5'd24 && shreg[23];
  assign wa     = shreg[22:16];
  assign wd     = shreg[15:0];

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      WR_STB <= 1'b0;
      r0     <= 15'h703E;
      r1     <= 16'h4000;
      fcw    <= 23'h044000;
      r3     <= 15'h6100;
      r4     <= 10'h000;
      r5     <= 15'h77A0;
      r6     <= 10'h2B6;
      r7     <= 10'h15B;
      r8     <= 10'h032;
      r9     <= 10'h032;
    end else begin
      WR_STB <= 1'b0;
      if (commit) begin
        case (wa)
          7'h00: begin r0  <= wd[14:0]; WR_STB <= 1'b1; end
          7'h01: begin r1  <= wd; WR_STB <= 1'b1; end
          7'h02: begin fcw <= {wd[6:0], r1}; WR_STB <= 1'b1; end
          7'h03: begin r3  <= wd[14:0]; WR_STB <= 1'b1; end
          7'h04: begin r4  <= wd[9:0]; WR_STB <= 1'b1; end
          7'h05: begin r5  <= wd[14:0]; WR_STB <= 1'b1; end
          7'h06: begin r6  <= wd[9:0]; WR_STB <= 1'b1; end
          7'h07: begin r7  <= wd[9:0]; WR_STB <= 1'b1; end
          7'h08: begin r8  <= wd[9:0]; WR_STB <= 1'b1; end
          7'h09: begin r9  <= wd[9:0]; WR_STB <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  assign FCW_FOD          = fcw;
  assign SYS_EN           = r0[0];
  assign DSM_SYNC_NRST_EN = r0[1];
  assign NCO_SYNC_NRST_EN = r0[2];
  assign FREQ_HOP         = r0[3];
  assign RT_EN            = r0[4];
  assign PCALI_EN         = r0[5];
  assign FREQ_C_EN        = r0[6];
  assign FREQ_C_MODE      = r0[7];
  assign DTCCALI_EN       = r0[8];
  assign OFSTCALI_EN      = r0[9];
  assign FCW_DN_EN        = r0[10];
  assign FCW_DN_WEIGHT    = r0[12:11];
  assign PSEG             = r0[14:13];
  assign FREQ_C_KS        = r3[4:0];
  assign PCALI_KS         = r3[9:5];
  assign PCALI_FREQDOWN   = r3[12:10];
  assign CALIORDER        = r3[14:13];
  assign PHASE_CTRL       = r4;
  assign KB               = r5[4:0];
  assign KC               = r5[9:5];
  assign KD               = r5[14:10];
  assign KDTCB_INIT       = r6;
  assign KDTCC_INIT       = r7;
  assign KDTCD_INIT0      = r8;
  assign KDTCD_INIT1      = r9;

endmodule

// File: tb/tb_fod_spi_regfile.sv
// Directed bench for fod_spi_regfile: SPI frames at SCK = CLK/8,
// hand-computed register, strobe and read-back expectations.
module tb_fod_spi_regfile;

  localparam int SS = 2;

  logic CLK = 1'b0;
  logic NARST, SCK, CSN, MOSI;
  logic MISO, WR_STB;
  logic [22:0] FCW_FOD;
  logic SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP, RT_EN;
  logic PCALI_EN, FREQ_C_EN, FREQ_C_MODE, DTCCALI_EN, OFSTCALI_EN;
  logic FCW_DN_EN;
  logic [1:0] FCW_DN_WEIGHT, PSEG, CALIORDER;
  logic [4:0] FREQ_C_KS, PCALI_KS, KB, KC, KD;
  logic [2:0] PCALI_FREQDOWN;
  logic [9:0] PHASE_CTRL, KDTCB_INIT, KDTCC_INIT, KDTCD_INIT0, KDTCD_INIT1;

  fod_spi_regfile #(.SYNC_STAGES(SS), .CHIP_ID(16'hF0D1)) dut (
    .CLK(CLK), .NARST(NARST), .SCK(SCK), .CSN(CSN), .MOSI(MOSI),
    .MISO(MISO), .WR_STB(WR_STB), .FCW_FOD(FCW_FOD),
    .SYS_EN(SYS_EN), .DSM_SYNC_NRST_EN(DSM_SYNC_NRST_EN),
    .NCO_SYNC_NRST_EN(NCO_SYNC_NRST_EN), .FREQ_HOP(FREQ_HOP),
    .RT_EN(RT_EN), .PCALI_EN(PCALI_EN), .FREQ_C_EN(FREQ_C_EN),
    .FREQ_C_MODE(FREQ_C_MODE), .DTCCALI_EN(DTCCALI_EN),
    .OFSTCALI_EN(OFSTCALI_EN), .FCW_DN_EN(FCW_DN_EN),
    .FCW_DN_WEIGHT(FCW_DN_WEIGHT), .PSEG(PSEG),
    .FREQ_C_KS(FREQ_C_KS), .PCALI_KS(PCALI_KS),
    .PCALI_FREQDOWN(PCALI_FREQDOWN), .CALIORDER(CALIORDER),
    .PHASE_CTRL(PHASE_CTRL), .KB(KB), .KC(KC), .KD(KD),
    .KDTCB_INIT(KDTCB_INIT), .KDTCC_INIT(KDTCC_INIT),
    .KDTCD_INIT0(KDTCD_INIT0), .KDTCD_INIT1(KDTCD_INIT1)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;
  int stb_cnt;
  int stb_at;
  int tcyc;
  logic [15:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      tcyc++;
      if (WR_STB) begin
        stb_cnt++;
        if (stb_at < 0) stb_at = tcyc;
      end
    end
  endtask

  // rst_at > 0 pulses NARST after that many bits
  task automatic spi_xfer(input int nbits, input logic [23:0] frame,
                          input int rst_at, output logic [15:0] rdata);
    stb_cnt = 0;
    stb_at  = -1;
    tcyc    = -1000;
    rdata   = '0;
    CSN = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 24) ? frame[23-i] : 1'b0;
      tick(4);
      if (i >= 8 && i < 24) rdata = {rdata[14:0], MISO};
      SCK = 1'b1;
      tick(4);
      SCK = 1'b0;
      if (rst_at == i + 1) begin
        NARST = 1'b0;
        tick(2);
        NARST = 1'b1;
      end
    end
    tick(4);
    CSN = 1'b1;
    tcyc = 0;
    tick(12);
  endtask

  initial begin
    NARST = 1'b0;
    SCK   = 1'b0;
    CSN   = 1'b1;
    MOSI  = 1'b0;
    stb_cnt = 0;
    stb_at  = -1;
    tcyc    = 0;
    tick(3);
    NARST = 1'b1;
    tick(6);

    chk("rst_fcw", FCW_FOD, 23'h044000);
    chk("rst_pcali_ks", PCALI_KS, 5'd8);
    chk("rst_kc", KC, 5'b11101);
    chk("rst_kdtcb", KDTCB_INIT, 10'd694);
    chk("rst_sys_en", SYS_EN, 1'b0);
    chk("rst_miso", MISO, 1'b0);
    chk("rst_wr_stb", WR_STB, 1'b0);
    chk("rst_pseg", PSEG, 2'b11);
    chk("rst_kdtcd1", KDTCD_INIT1, 10'd50);

    spi_xfer(24, {1'b0, 7'h05, 16'h0000}, 0, rd);
    chk("rd_05", rd, 16'h77A0);
    chk("rd_05_stb", stb_cnt, 0);
    chk("miso_idle", MISO, 1'b0);
    spi_xfer(24, {1'b0, 7'h7F, 16'h0000}, 0, rd);
    chk("rd_7f", rd, 16'hF0D1);
    spi_xfer(24, {1'b0, 7'h20, 16'h0000}, 0, rd);
    chk("rd_20", rd, 16'h0000);
    spi_xfer(24, {1'b0, 7'h06, 16'h0000}, 0, rd);
    chk("rd_06", rd, 16'h02B6);

    spi_xfer(24, {1'b1, 7'h00, 16'h0301}, 0, rd);
    chk("wr0_sys_en", SYS_EN, 1'b1);
    chk("wr0_dtccali", DTCCALI_EN, 1'b1);
    chk("wr0_ofstcali", OFSTCALI_EN, 1'b1);
    chk("wr0_rt_en", RT_EN, 1'b0);
    chk("wr0_pseg", PSEG, 2'b00);
    chk("wr0_stb_cnt", stb_cnt, 1);
    chk("wr0_stb_lat", stb_at, SS + 2);
    spi_xfer(24, {1'b0, 7'h00, 16'h0000}, 0, rd);
    chk("rd_00", rd, 16'h0301);

    spi_xfer(24, {1'b1, 7'h01, 16'h8000}, 0, rd);
    chk("fcw_stage_hold", FCW_FOD, 23'h044000);
    chk("fcw_stage_stb", stb_cnt, 1);
    spi_xfer(24, {1'b1, 7'h02, 16'h0005}, 0, rd);
    chk("fcw_commit", FCW_FOD, 23'h058000);
    spi_xfer(24, {1'b0, 7'h01, 16'h0000}, 0, rd);
    chk("rd_01", rd, 16'h8000);
    spi_xfer(24, {1'b0, 7'h02, 16'h0000}, 0, rd);
    chk("rd_02", rd, 16'h0005);

    spi_xfer(24, {1'b1, 7'h7F, 16'h1234}, 0, rd);
    chk("wr7f_stb", stb_cnt, 0);
    spi_xfer(24, {1'b1, 7'h20, 16'h1234}, 0, rd);
    chk("wr20_stb", stb_cnt, 0);
    spi_xfer(24, {1'b0, 7'h7F, 16'h0000}, 0, rd);
    chk("rd_7f_again", rd, 16'hF0D1);

    spi_xfer(23, {1'b1, 7'h04, 16'h0155}, 0, rd);
    chk("abort23_phase", PHASE_CTRL, 10'd0);
    chk("abort23_stb", stb_cnt, 0);
    spi_xfer(25, {1'b1, 7'h04, 16'h0155}, 0, rd);
    chk("abort25_phase", PHASE_CTRL, 10'd0);
    chk("abort25_stb", stb_cnt, 0);
    spi_xfer(24, {1'b1, 7'h04, 16'hFD55}, 0, rd);
    chk("wr04_phase", PHASE_CTRL, 10'h155);

    spi_xfer(24, {1'b1, 7'h06, 16'h0123}, 12, rd);
    chk("midrst_kdtcb", KDTCB_INIT, 10'd694);
    chk("midrst_stb", stb_cnt, 0);
    chk("midrst_fcw", FCW_FOD, 23'h044000);
    chk("midrst_sys_en", SYS_EN, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fod_spi_regfile.md
# fod_spi_regfile

SPI slave register file that receives serial configuration frames and drives the FOD digital-controller control bus: FCW, phase-cal, INL-cal, DTC gain and sync/enable controls. It is the receiving end of the FOD SPI control interface and replaces static control stimulus with a writable and readable register map. It sits between the chip SPI pads and the FOD controller, in the controller's clock domain.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the SCK/CSN/MOSI synchronizers (≥2).
- CHIP_ID, 16'hF0D1, read-only value at address 0x7F.
- CLK  in  1  controller clock; SCK must be ≤ CLK/8.
- NARST  in  1  reset. Asynchronous, active-low.
- SCK, CSN, MOSI  in  1 each  SPI pins: mode 0, MSB first, CSN active-low.
- MISO  out  1  read data; 0 whenever CSN is high.
- WR_STB  out  1  one-CLK pulse on every committed write to a mapped writable address.
- FCW_FOD  out  23  unsigned fixed point, 7 integer bits and 16 fractional bits.
- Other outputs, each with the same width as its register field: SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP, RT_EN, PCALI_EN, FREQ_C_EN, FREQ_C_MODE, DTCCALI_EN, OFSTCALI_EN, FCW_DN_EN, FCW_DN_WEIGHT[1:0], PSEG[1:0], FREQ_C_KS[4:0], PCALI_KS[4:0], PCALI_FREQDOWN[2:0], CALIORDER[1:0], PHASE_CTRL[9:0], KB/KC/KD[4:0] (two's complement), KDTCB_INIT, KDTCC_INIT, KDTCD_INIT0, KDTCD_INIT1 [9:0].

## Operation
- **Frame format:** 24 bits = {RW (1 = write), ADDR[6:0], DATA[15:0]}.
- **Sampling:** MOSI is sampled on synchronized SCK rising edges while CSN is low.
- **Bit counter:** 5 bits, cleared on CSN fall, saturates at 25.
- **Write commit:** occurs on the synchronized CSN rising edge, only if RW = 1 and the count is exactly 24. Any other count discards the frame, with no register change and no WR_STB.
- **Read:** after 8 bits with RW = 0, the addressed register is loaded into a 16-bit shift-out register. MISO presents bit 15 before the 9th rising SCK edge, then shifts on each subsequent SCK falling edge. MISO = 0 during header bits.
- **Unmapped addresses:** read 0; writes are ignored (no WR_STB).
- **Address 0x7F:** reads CHIP_ID; writes are ignored.
- **Register map and reset values.** Unlisted bits are reserved: they read 0 and writes are ignored.
  - **0x00 = 0x703E.**
    - Bits [0..10]: SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP, RT_EN, PCALI_EN, FREQ_C_EN, FREQ_C_MODE, DTCCALI_EN, OFSTCALI_EN, FCW_DN_EN.
    - [12:11] FCW_DN_WEIGHT; [14:13] PSEG.
  - **0x01 = 0x4000:** FCW low-staging register (16 bits).
  - **0x02 = 0x0004:** [6:0] FCW high. A write sets FCW_FOD = {DATA[6:0], staging} atomically.
  - **0x03 = 0x6100:** [4:0] FREQ_C_KS, [9:5] PCALI_KS, [12:10] PCALI_FREQDOWN, [14:13] CALIORDER.
  - **0x04 = 0x0000:** [9:0] PHASE_CTRL.
  - **0x05 = 0x77A0:** [4:0] KB, [9:5] KC, [14:10] KD. Reset values are KB = 0, KC = KD = −3.
  - **0x06 = 0x02B6:** KDTCB_INIT (694).
  - **0x07 = 0x015B:** KDTCC_INIT (347).
  - **0x08, 0x09 = 0x0032:** KDTCD_INIT0 and KDTCD_INIT1 (50).
- **FCW_FOD:** resets to 0x044000 (4.25). Writing 0x01 alone does not change FCW_FOD. Reading 0x01 returns the staging register; reading 0x02 returns FCW_FOD[22:16].
- **Output reset values:** all outputs equal their register reset fields. WR_STB = 0; MISO = 0.

## Timing
- **Input path:** each of SCK, CSN and MOSI passes through a SYNC_STAGES-deep synchronizer, then an edge detector registered on CLK.
- **Write latency:** register outputs and the WR_STB pulse update on the same CLK edge, exactly 1 CLK after the CLK cycle in which the synchronized CSN rise is detected. That is SYNC_STAGES+2 CLK after the pin edge.
- **Read load:** the shift-out register loads 1 CLK after detection of the 8th SCK rise.
- **MISO lag:** MISO changes SYNC_STAGES+1 CLK after the SCK pin falls. With SCK ≤ CLK/8 this is stable before the next rising SCK edge.
- **Reset mid-frame:** NARST low immediately returns all registers and outputs to reset values and clears the counter, shift registers and synchronizers. A frame in progress when NARST rises is discarded, because its count cannot reach exactly 24 without a CSN fall.
- **Simultaneous events:** a CSN rise coinciding with an SCK edge commits based on the count before that edge. A CSN fall clears the counter, taking priority over an SCK rise in the same cycle.

## Test plan
- **Reset:** release NARST, no SPI traffic → FCW_FOD = 0x044000, PCALI_KS = 8, KC = 5'b11101, KDTCB_INIT = 694, SYS_EN = 0, MISO = 0.
- **Register write:** write 0x00 ← 0x0301 → SYS_EN = 1, DTCCALI_EN = 1, OFSTCALI_EN = 1, RT_EN = 0. WR_STB is high for exactly 1 CLK, SYNC_STAGES+2 CLK after the CSN rise.
- **Atomic FCW:** write 0x01 ← 0x8000 → FCW_FOD unchanged at 0x044000. Then write 0x02 ← 0x0005 → FCW_FOD = 0x058000.
- **Reads:** read 0x05 after reset → MISO returns 0x77A0, MSB first. Read 0x7F → 0xF0D1. Read 0x20 → 0x0000.
- **Aborted frames:** a 23-bit write to 0x04 and a 25-bit write → PHASE_CTRL stays 0 and no WR_STB.
- **Reset mid-write:** NARST pulsed after 12 bits of a write to 0x06, then CSN rises → KDTCB_INIT = 694 and no WR_STB.
